rf_arb: RTL
===========

RF_ARB -- requirements
Module: rf_arb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64, meaning the busy-phase watchdog limit in clk cycles; it is used only with RF_ARB_TIMEOUT_EN.
REQ-002 SHALL have parameter ADDR_W, default 10, meaning the radio register address width.
REQ-003 Port clk: input, 1 bit, the single clock.
REQ-004 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-005 Port req_valid: input, 2 bits, one request strobe per requester (0 = host, 1 = IRQ service).
REQ-006 Port req_mode: input, 2x2 bits, per-requester op code: 00 short rd, 01 short wr, 10 long rd, 11 long wr.
REQ-007 Port req_addr: input, 2xADDR_W bits, per-requester register address.
REQ-008 Port req_wdata: input, 2x8 bits, per-requester write data.
REQ-009 Port req_ack: output, 2 bits, one-cycle accept pulse per requester.
REQ-010 Port rsp_valid: output, 1 bit, one-cycle completion pulse.
REQ-011 Port rsp_id: output, 1 bit, index of the requester that completed.
REQ-012 Port rsp_rdata: output, 8 bits, read data captured MSB first; 0 for writes.
REQ-013 Port rsp_err: output, 1 bit, timeout flag for the completed op.
REQ-014 Port eng_c_en: output, 1 bit, command enable to the SPI register engine.
REQ-015 Port eng_mode: output, 2 bits, op code to the engine.
REQ-016 Port eng_addr: output, ADDR_W bits, address to the engine.
REQ-017 Port eng_wdata: output, 8 bits, write data to the engine.
REQ-018 Port eng_ready: input, 1 bit, engine idle indication.
REQ-019 Port eng_sdo: input, 1 bit, serial read data returned by the engine.

Function
REQ-020 SHALL implement the FSM IDLE -> LAUNCH -> BUSY -> DONE -> IDLE, with all transitions on the rising edge of clk.
REQ-021 IDLE: when any req_valid is 1 and eng_ready is 1, SHALL grant one requester, latch its mode/addr/wdata, pulse its req_ack for 1 cycle, and go to LAUNCH.
REQ-022 Arbitration SHALL be round-robin: on simultaneous requests, the requester not granted last wins; after reset, requester 0 has priority.
REQ-023 A granted requester SHALL NOT be re-granted while its op is outstanding; req_ack SHALL never be high on both bits at once.
REQ-024 LAUNCH: eng_c_en SHALL be 1 and eng_mode/eng_addr/eng_wdata SHALL carry the latched values; SHALL move to BUSY on the first cycle eng_ready samples 0.
REQ-025 BUSY: eng_c_en SHALL be 0 and the engine outputs SHALL stay stable; a cycle counter SHALL start at 0 on BUSY entry.
REQ-026 Reads SHALL shift eng_sdo into rdata MSB first at counter values 7..14 (short) or 15..22 (long).
REQ-027 SHALL leave BUSY for DONE when eng_ready samples 1.
REQ-028 DONE: SHALL assert rsp_valid for exactly 1 cycle with rsp_id, rsp_rdata and rsp_err, then return to IDLE.
REQ-029 Requests arriving during LAUNCH, BUSY or DONE SHALL be held off (no req_ack); requesters keep req_valid high until acked.
REQ-030 Minimum issue-to-issue spacing SHALL be 1 idle cycle after DONE; back-to-back requests alternate between requesters.

Reset
REQ-031 When rst_n=0, SHALL asynchronously force state IDLE and set req_ack=0, rsp_valid=0, rsp_id=0, rsp_rdata=0, rsp_err=0, eng_c_en=0, eng_mode=0, eng_addr=0, eng_wdata=0, with round-robin pointer = requester 0.
REQ-032 A reset in mid-operation SHALL drop the op silently with no rsp_valid; requesters re-issue.

Configuration
REQ-033 With RF_ARB_TIMEOUT_EN defined: if BUSY or LAUNCH lasts TIMEOUT_CYC cycles, SHALL go to DONE with rsp_err=1 and rsp_rdata=0.
REQ-034 Without RF_ARB_TIMEOUT_EN, SHALL wait indefinitely, and rsp_err SHALL be tied to 0.

Structure
REQ-035 Package rf_pkg SHALL hold the op-code enum (SHORT_RD, SHORT_WR, LONG_RD, LONG_WR), the FSM state enum, the read-capture window constants (7, 15, 8) and the default TIMEOUT_CYC.
REQ-036 SHALL contain one sub-module, rf_rr_arb2: the 2-way round-robin arbiter with its pointer register.

Verification
REQ-037 Host short read, addr 0x12, engine model returns 0xA5 -> one req_ack[0]; rsp_valid with rsp_id=0, rsp_rdata=0xA5, rsp_err=0.
REQ-038 IRQ long write, addr 0x200, wdata 0x3C -> eng_mode=11, eng_addr=0x200, eng_wdata=0x3C stable through BUSY; rsp_rdata=0.
REQ-039 Both requesters valid continuously, 4 ops -> grant order 0,1,0,1; never two acks in the same cycle.
REQ-040 Reset pulled low during BUSY of a long read -> all outputs are 0 immediately, no rsp_valid; the next request is served normally.
REQ-041 RF_ARB_TIMEOUT_EN, engine holds eng_ready=0 -> rsp_valid with rsp_err=1 exactly TIMEOUT_CYC cycles after LAUNCH; the same stimulus without the macro -> no response.

Source files
------------

// File: rtl/rf_pkg.sv
`default_nettype none
//============================================================================
// Module   : rf_pkg
// Purpose  : Shared types and constants for the radio register arbiter.
//            Holds the op-code encoding, the arbiter FSM state encoding,
//            the read-capture window constants and the default watchdog
//            limit.
// Revision : 1.0 - initial release
//============================================================================
package rf_pkg;

  // Op code carried from a requester to the SPI register engine.
  // Bit 0 set means write, bit 1 set means long (two-byte header) access.
  typedef enum logic [1:0] {
    SHORT_RD = 2'b00,
    SHORT_WR = 2'b01,
    LONG_RD  = 2'b10,
    LONG_WR  = 2'b11
  } rf_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    DONE   = 2'd3
  } rf_state_e;

  // Busy-phase counter value at which the first read data bit appears.
  localparam int unsigned C_RD_START_SHORT  = 7;
  localparam int unsigned C_RD_START_LONG   = 15;
  // Number of read data bits captured.
  localparam int unsigned C_RD_BITS         = 8;
  // Default busy-phase watchdog limit in clk cycles.
  localparam int unsigned C_TIMEOUT_CYC_DEF = 64;

  function automatic logic op_is_read(input rf_op_e op);
    return ~op[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_rr_arb2.sv
`default_nettype none
//============================================================================
// Module   : rf_rr_arb2
// Purpose  : Two-way round-robin arbiter. The requester that was not granted
//            last has priority; after reset requester 0 has priority.
// Ports    : clk, rst_n  - clock, asynchronous active-low reset
//            req[1:0]    - request vector
//            en          - a grant is being taken this cycle (moves pointer)
//            grant[1:0]  - one-hot (or zero) combinational grant
// Revision : 1.0 - initial release
//============================================================================
module rf_rr_arb2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  // Index of the requester currently holding priority.
  logic r_prio;

  always_comb begin
    grant = 2'b00;
    if (req[r_prio]) begin
      grant[r_prio] = 1'b1;
    end else if (req[~r_prio]) begin
      grant[~r_prio] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (en && (|req)) begin
      // Priority passes to the requester that just lost (or did not ask).
      r_prio <= ~grant[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/rf_arb.sv
`default_nettype none
//============================================================================
// Module   : rf_arb
// Purpose  : Arbitrates two requesters (0 = host, 1 = IRQ service) onto one
//            SPI radio register engine. One op is in flight at a time:
//            IDLE -> LAUNCH -> BUSY -> DONE -> IDLE. Read data is shifted in
//            MSB first from eng_sdo during a fixed busy-counter window.
// Config   : RF_ARB_TIMEOUT_EN - when defined, a LAUNCH+BUSY phase lasting
//            TIMEOUT_CYC cycles is aborted to DONE with rsp_err=1 and
//            rsp_rdata=0. When undefined the arbiter waits indefinitely and
//            rsp_err is tied low.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            req_valid/mode/addr/wdata  - per-requester request
//            req_ack                    - one-cycle accept pulse
//            rsp_valid/id/rdata/err     - one-cycle completion
//            eng_c_en/mode/addr/wdata   - command to the SPI engine
//            eng_ready, eng_sdo         - engine status and serial read data
// Revision : 1.0 - initial release
//============================================================================
module rf_arb
  import rf_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = C_TIMEOUT_CYC_DEF,
  parameter int unsigned ADDR_W      = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  input  logic [1:0][1:0]        req_mode,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][7:0]        req_wdata,
  output logic [1:0]             req_ack,
  output logic                   rsp_valid,
  output logic                   rsp_id,
  output logic [7:0]             rsp_rdata,
  output logic                   rsp_err,
  output logic                   eng_c_en,
  output logic [1:0]             eng_mode,
  output logic [ADDR_W-1:0]      eng_addr,
  output logic [7:0]             eng_wdata,
  input  logic                   eng_ready,
  input  logic                   eng_sdo
);

  localparam logic [4:0] C_CNT_MAX   = 5'h1f;
  localparam logic [4:0] C_WIN_SHORT = 5'(C_RD_START_SHORT);
  localparam logic [4:0] C_WIN_LONG  = 5'(C_RD_START_LONG);
  localparam logic [4:0] C_WIN_LEN   = 5'(C_RD_BITS);

  rf_state_e         r_state;
  rf_state_e         w_state_nxt;
  logic [1:0]        w_grant;
  logic              w_gid;
  logic              w_take;
  rf_op_e            r_mode;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic [7:0]        r_rdata;
  logic              r_id;
  logic [1:0]        r_ack;
  logic [4:0]        r_cnt;
  logic [4:0]        w_win_lo;
  logic              w_in_win;
  logic              w_shift;
  logic              w_busy_done;
  logic              w_timeout;
  logic              w_to_err;

  // A grant is only taken from IDLE with the engine idle; this alone keeps
  // a requester from being re-granted while its op is outstanding.
  assign w_take = (r_state == IDLE) && eng_ready && (|req_valid);
  assign w_gid  = w_grant[1];

  rf_rr_arb2 u_rr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_valid),
    .en    (w_take),
    .grant (w_grant)
  );

  assign w_win_lo    = r_mode[1] ? C_WIN_LONG : C_WIN_SHORT;
  assign w_in_win    = (r_cnt >= w_win_lo) && (r_cnt < (w_win_lo + C_WIN_LEN));
  assign w_shift     = (r_state == BUSY) && op_is_read(r_mode) && w_in_win;
  assign w_busy_done = (r_state == BUSY) && eng_ready;

`ifdef RF_ARB_TIMEOUT_EN
  // Watchdog spans LAUNCH and BUSY together, starting at the grant edge, so
  // DONE follows the first LAUNCH cycle by exactly TIMEOUT_CYC cycles.
  localparam int unsigned     C_WD_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [C_WD_W-1:0] C_WD_LAST = C_WD_W'(TIMEOUT_CYC - 1);

  logic [C_WD_W-1:0] r_wd;
  logic              r_err;
  logic              w_active;

  assign w_active  = (r_state == LAUNCH) || (r_state == BUSY);
  assign w_timeout = w_active && (r_wd == C_WD_LAST);
  // A normal completion in the same cycle as expiry wins.
  assign w_to_err  = w_timeout && !w_busy_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_take) begin
        r_wd  <= '0;
        r_err <= 1'b0;
      end else if (w_active && (r_wd != C_WD_LAST)) begin
        r_wd <= r_wd + 1'b1;
      end
      if (w_to_err) begin
        r_err <= 1'b1;
      end
    end
  end

  assign rsp_err = (r_state == DONE) && r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYC == 0);
  assign w_timeout        = 1'b0;
  assign w_to_err         = 1'b0;
  assign rsp_err          = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and state-decoded outputs.
  always_comb begin
    w_state_nxt = r_state;
    eng_c_en    = 1'b0;
    rsp_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_take) begin
          w_state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        eng_c_en = 1'b1;
        if (w_timeout) begin
          w_state_nxt = DONE;
        end else if (!eng_ready) begin
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (eng_ready || w_timeout) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        rsp_valid   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Request latch, busy counter and read capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack   <= 2'b00;
      r_id    <= 1'b0;
      r_mode  <= SHORT_RD;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      r_ack <= 2'b00;
      if (w_take) begin
        r_ack   <= w_grant;
        r_id    <= w_gid;
        r_mode  <= rf_op_e'(req_mode[w_gid]);
        r_addr  <= req_addr[w_gid];
        r_wdata <= req_wdata[w_gid];
        r_rdata <= '0;
      end

      // Counter reads 0 in the first BUSY cycle; saturates so it can never
      // wrap back into a capture window on a slow engine.
      if (r_state == LAUNCH) begin
        r_cnt <= '0;
      end else if ((r_state == BUSY) && (r_cnt != C_CNT_MAX)) begin
        r_cnt <= r_cnt + 5'd1;
      end

      if (w_to_err) begin
        r_rdata <= '0;
      end else if (w_shift) begin
        r_rdata <= {r_rdata[6:0], eng_sdo};
      end
    end
  end

  assign req_ack   = r_ack;
  assign eng_mode  = r_mode;
  assign eng_addr  = r_addr;
  assign eng_wdata = r_wdata;
  assign rsp_id    = (r_state == DONE) && r_id;
  assign rsp_rdata = (r_state == DONE) ? r_rdata : 8'h00;

endmodule
`default_nettype wire
